// File: rtl/datapath_sequencer.sv
// Purpose : single-op command sequencer for the RA/RB/RZ datapath. It drives the register load enables and the bus-select enables.
// Latency : LDA/MOV done at k+2, ADD at k+3, ADDN(n) at k+1+2n, ADDN(0) at k+1, where k is the edge at which start is sampled.
// Backpressure: start is accepted only in IDLE and is dropped while busy. Optional SEQ_HOLD_EN adds a hold input that freezes the sequence.
module datapath_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
`ifdef SEQ_HOLD_EN
  input  logic             hold,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LDA    = 3'd1;
  localparam logic [2:0] S_MOV    = 3'd2;
  localparam logic [2:0] S_ADD_Z  = 3'd3;
  localparam logic [2:0] S_ADD_WB = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_ADDN = 2'b11;

  localparam logic [CNT_W-1:0] REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic [CNT_W-1:0] rem_dec;
  logic             frz;

  // The freeze request exists only when the hold feature is built in.
`ifdef SEQ_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  // The remaining-iteration counter decrements on every write-back. It never wraps because the loop exits when the result reaches zero.
  assign rem_dec = rem - REM_ONE;

  // Next-state and next-count logic. A frozen cycle holds both the state and rem.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (!frz) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_LDA: state_nxt = S_LDA;
              OP_MOV: state_nxt = S_MOV;
              OP_ADD: begin
                state_nxt = S_ADD_Z;
                rem_nxt   = REM_ONE;
              end
              OP_ADDN: begin
                if (count != '0) begin
                  state_nxt = S_ADD_Z;
                  rem_nxt   = count;
                end else begin
                  // A zero repeat count completes without touching the datapath.
                  state_nxt = S_DONE;
                end
              end
              default: state_nxt = S_IDLE;
            endcase
          end
        end
        S_LDA:    state_nxt = S_DONE;
        S_MOV:    state_nxt = S_DONE;
        S_ADD_Z:  state_nxt = S_ADD_WB;
        S_ADD_WB: begin
          rem_nxt   = rem_dec;
          state_nxt = (rem_dec != '0) ? S_ADD_Z : S_DONE;
        end
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // State and counter registers. Clear drops the sequencer to IDLE asynchronously, even in the middle of an operation.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Moore decode of the enables from the registered state. Hold masks the enables and done, but busy still reflects the state.
  always_comb begin
    RAin  = 1'b0;
    RBin  = 1'b0;
    RZin  = 1'b0;
    RAout = 1'b0;
    RBout = 1'b0;
    RZout = 1'b0;
    done  = 1'b0;
    busy  = (state != S_IDLE);
    if (!frz) begin
      case (state)
        S_LDA: RAin = 1'b1;
        S_MOV: begin
          RAout = 1'b1;
          RBin  = 1'b1;
        end
        S_ADD_Z: begin
          RBout = 1'b1;
          RZin  = 1'b1;
        end
        S_ADD_WB: begin
          RZout = 1'b1;
          RBin  = 1'b1;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small RA/RB/RZ datapath model.
// Every cycle, the bench checks that the bus enables are one-hot-or-zero and that no output is X.
// Build with SEQ_HOLD_EN defined to exercise the hold input as well.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [1:0] op;
  logic [3:0] count;
  logic       RAin, RBin, RZin, RAout, RBout, RZout, busy, done;
`ifdef SEQ_HOLD_EN
  logic       hold = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // outs = {RAin,RBin,RZin,RAout,RBout,RZout,busy,done}
  localparam logic [7:0] O_IDLE = 8'h00;
  localparam logic [7:0] O_LDA  = 8'h82;
  localparam logic [7:0] O_MOV  = 8'h52;
  localparam logic [7:0] O_ADDZ = 8'h2A;
  localparam logic [7:0] O_ADDW = 8'h46;
  localparam logic [7:0] O_DONE = 8'h03;
  localparam logic [7:0] O_HELD = 8'h02;

  logic [7:0] outs;
  assign outs = {RAin, RBin, RZin, RAout, RBout, RZout, busy, done};

  // Datapath model: RA loads the immediate, RB loads from the bus, RZ = RA + bus.
  logic [7:0] ra = 8'd0, rb = 8'd0, rz = 8'd0;
  logic [7:0] imm = 8'd0, rb_val = 8'd0;
  logic       rb_ld = 1'b0;
  logic [7:0] bus;
  assign bus = RAout ? ra : RBout ? rb : RZout ? rz : 8'd0;

  always @(posedge clk) begin
    if (RAin) ra <= imm;
    if (RBin) rb <= bus;
    else if (rb_ld) rb <= rb_val;
    if (RZin) rz <= ra + bus;
  end

  datapath_sequencer #(.CNT_W(4)) dut (
    .clk   (clk),
    .clear (clear),
`ifdef SEQ_HOLD_EN
    .hold  (hold),
`endif
    .start (start),
    .op    (op),
    .count (count),
    .RAin  (RAin),
    .RBin  (RBin),
    .RZin  (RZin),
    .RAout (RAout),
    .RBout (RBout),
    .RZout (RZout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge. On return, the bench is at k+1.
  task automatic start_cmd(input logic [1:0] o, input logic [3:0] c);
    start = 1'b1;
    op    = o;
    count = c;
    step();
    start = 1'b0;
  endtask

  task automatic preload_rb(input logic [7:0] v);
    rb_ld  = 1'b1;
    rb_val = v;
    step();
    rb_ld  = 1'b0;
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    check("bus_onehot", 32'($countones({RAout, RBout, RZout}) <= 1), 32'd1);
    check("no_x", 32'($isunknown(outs)), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear = 1'b0;
    start = 1'b1;
    op    = 2'b10;
    count = 4'd0;

    // Reset holds everything low, even while a request is pending.
    step();
    check("rst_outs", 32'(outs), 32'(O_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    clear = 1'b1;
    step();
    check("rst_accept", 32'(outs), 32'(O_ADDZ));
    start = 1'b0;
    step(); check("rst_add_wb", 32'(outs), 32'(O_ADDW));
    step(); check("rst_add_done", 32'(outs), 32'(O_DONE));
    step(); check("rst_add_idle", 32'(outs), 32'(O_IDLE));

    // LDA: RAin at k+1, done at k+2, idle at k+3.
    imm = 8'd5;
    start_cmd(2'b00, 4'd0);
    check("lda_k1", 32'(outs), 32'(O_LDA));
    step();
    check("lda_k2", 32'(outs), 32'(O_DONE));
    check("lda_ra", 32'(ra), 32'd5);
    step();
    check("lda_k3", 32'(outs), 32'(O_IDLE));

    // ADD with A=5 and RB=3.
    preload_rb(8'd3);
    start_cmd(2'b10, 4'd0);
    check("add_k1", 32'(outs), 32'(O_ADDZ));
    step();
    check("add_k2", 32'(outs), 32'(O_ADDW));
    check("add_rz", 32'(rz), 32'd8);
    step();
    check("add_k3", 32'(outs), 32'(O_DONE));
    check("add_rb", 32'(rb), 32'd8);
    step();
    check("add_k4", 32'(outs), 32'(O_IDLE));

    // ADDN(3) with A=2 and RB=0 should give RB=6, with done at k+7.
    imm = 8'd2;
    start_cmd(2'b00, 4'd0);
    step(); step();
    preload_rb(8'd0);
    start_cmd(2'b11, 4'd3);
    for (int j = 0; j < 6; j++) begin
      check("addn3_seq", 32'(outs), 32'((j % 2 == 0) ? O_ADDZ : O_ADDW));
      step();
    end
    check("addn3_done", 32'(outs), 32'(O_DONE));
    check("addn3_rb", 32'(rb), 32'd6);
    step();
    check("addn3_idle", 32'(outs), 32'(O_IDLE));

    // ADDN(0) finishes at k+1 without touching the datapath.
    start_cmd(2'b11, 4'd0);
    check("addn0_done", 32'(outs), 32'(O_DONE));
    step();
    check("addn0_idle", 32'(outs), 32'(O_IDLE));
    check("addn0_rb", 32'(rb), 32'd6);

    // MOV: RB takes RA.
    start_cmd(2'b01, 4'd0);
    check("mov_k1", 32'(outs), 32'(O_MOV));
    step();
    check("mov_done", 32'(outs), 32'(O_DONE));
    check("mov_rb", 32'(rb), 32'd2);
    step();

    // A start raised while busy is ignored.
    start_cmd(2'b10, 4'd0);
    check("busy_k1", 32'(outs), 32'(O_ADDZ));
    start = 1'b1; op = 2'b11; count = 4'd5;
    step(); check("busy_wb", 32'(outs), 32'(O_ADDW));
    step(); check("busy_done", 32'(outs), 32'(O_DONE));
    step(); check("busy_idle", 32'(outs), 32'(O_IDLE));
    start = 1'b0;
    step(); check("busy_stay", 32'(outs), 32'(O_IDLE));
    check("busy_rb", 32'(rb), 32'd4);

    // Clear asserted mid-ADDN drops the enables immediately.
    start_cmd(2'b11, 4'd4);
    step(); step();
    check("clr_pre", 32'(outs), 32'(O_ADDZ));
    #2 clear = 1'b0;
    #1 check("clr_async", 32'(outs), 32'(O_IDLE));
    step(); check("clr_held", 32'(outs), 32'(O_IDLE));
    clear = 1'b1;
    step(); check("clr_idle", 32'(outs), 32'(O_IDLE));
    start_cmd(2'b11, 4'd1);
    check("post_clr_k1", 32'(outs), 32'(O_ADDZ));
    step(); check("post_clr_k2", 32'(outs), 32'(O_ADDW));
    step(); check("post_clr_k3", 32'(outs), 32'(O_DONE));
    step();

    // Maximum count: ADDN(15) finishes at k+31 with RB = 15*2.
    preload_rb(8'd0);
    start_cmd(2'b11, 4'd15);
    n = 1;
    while (outs !== O_DONE && n < 40) begin
      step();
      n++;
    end
    check("addn15_lat", 32'(n), 32'd31);
    check("addn15_rb", 32'(rb), 32'd30);
    step();
    check("addn15_idle", 32'(outs), 32'(O_IDLE));

`ifdef SEQ_HOLD_EN
    // Holding in ADD_Z for 3 cycles delays done by 3 cycles.
    start_cmd(2'b10, 4'd0);
    hold = 1'b1;
    #1 check("hold_mask", 32'(outs), 32'(O_HELD));
    step(); step(); step();
    check("hold_frozen", 32'(outs), 32'(O_HELD));
    hold = 1'b0;
    #1 check("hold_resume", 32'(outs), 32'(O_ADDZ));
    step(); check("hold_wb", 32'(outs), 32'(O_ADDW));
    // A frozen DONE re-emits done when hold is released.
    step();
    hold = 1'b1;
    #1 check("hold_done_mask", 32'(outs), 32'(O_HELD));
    step();
    hold = 1'b0;
    #1 check("hold_done_again", 32'(outs), 32'(O_DONE));
    step(); check("hold_done_idle", 32'(outs), 32'(O_IDLE));
    // Hold in IDLE blocks a start request.
    hold = 1'b1; start = 1'b1; op = 2'b00;
    step(); step();
    check("hold_idle_block", 32'(outs), 32'(O_IDLE));
    hold = 1'b0;
    step();
    start = 1'b0;
    check("hold_idle_accept", 32'(outs), 32'(O_LDA));
    step(); step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
